// File: rtl/esp_tx_serializer.sv
// FIFO-buffered 16-bit serializer driving an ESP8266 SCLK/IO_SPI link, one framed word at a time.
// Optional even-parity bit per frame when ESP_TX_PARITY_EN is defined.
module esp_tx_serializer #(
    parameter int CLK_DIV    = 50,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        HCLK,
    input  logic                        HRESETn,
    input  logic                        wr_valid,
    input  logic [15:0]                 wr_data,
    output logic                        wr_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        busy,
    output logic                        done,
    output logic                        SCLK,
    output logic                        IO_SPI
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CNW = AW + 1;
    localparam int CW  = $clog2(4 * CLK_DIV);
`ifdef ESP_TX_PARITY_EN
    localparam int FW = 18;
`else
    localparam int FW = 17;
`endif

    localparam logic [CW-1:0]  C_HALF     = CW'(CLK_DIV);
    localparam logic [CW-1:0]  C_BIT_END  = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0]  C_GAP_END  = CW'(4 * CLK_DIV - 1);
    localparam logic [4:0]     C_LAST_BIT = 5'(FW - 1);
    localparam logic [CNW-1:0] C_DEPTH    = CNW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [4:0]     r_bit;
    logic [FW-1:0]  r_shift;
    logic           r_sclk;
    logic           r_io;
    logic           r_done;
    logic [15:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [CNW-1:0] r_count;

    state_t         w_state_nxt;
    logic [CW-1:0]  w_cnt_nxt;
    logic [4:0]     w_bit_nxt;
    logic [FW-1:0]  w_shift_nxt;
    logic [FW-1:0]  w_frame;
    logic [15:0]    w_head;
    logic           w_pop;
    logic           w_push;
    logic           w_done_nxt;
    logic           w_sclk_nxt;
    logic           w_io_nxt;

    assign wr_ready   = (r_count < C_DEPTH);
    assign w_push     = wr_valid & wr_ready;
    assign fifo_count = r_count;
    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;
    assign SCLK       = r_sclk;
    assign IO_SPI     = r_io;
    assign w_head     = r_mem[r_rptr];

`ifdef ESP_TX_PARITY_EN
    assign w_frame = {1'b1, w_head, ^w_head};
`else
    assign w_frame = {1'b1, w_head};
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CW'(1);
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_pop       = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (r_count != '0) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_frame;
                    w_bit_nxt   = '0;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // End of the SCLK-high half: this edge is the SCLK falling edge.
                if (r_cnt == C_BIT_END) begin
                    w_cnt_nxt = '0;
                    if (r_bit == C_LAST_BIT) begin
                        w_state_nxt = S_GAP;
                        w_done_nxt  = 1'b1;
                        w_bit_nxt   = '0;
                    end else begin
                        w_bit_nxt   = r_bit + 5'd1;
                        w_shift_nxt = {r_shift[FW-2:0], 1'b0};
                    end
                end
            end
            S_GAP: begin
                if (r_cnt == C_GAP_END) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_bit_nxt   = '0;
            end
        endcase
        // Line outputs are registered from next-state values so they never glitch.
        w_sclk_nxt = (w_state_nxt == S_SHIFT) && (w_cnt_nxt >= C_HALF);
        w_io_nxt   = (w_state_nxt == S_SHIFT) && w_shift_nxt[FW-1];
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_sclk  <= 1'b0;
            r_io    <= 1'b0;
            r_done  <= 1'b0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_sclk  <= w_sclk_nxt;
            r_io    <= w_io_nxt;
            r_done  <= w_done_nxt;
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNW'(1);
                2'b01:   r_count <= r_count - CNW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESETn && w_push) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_esp_tx_serializer.sv
// Self-checking bench for esp_tx_serializer: vector table, corner sequences and a random run
// scored against a cycle-budget reference model. Honours ESP_TX_PARITY_EN.
module tb_esp_tx_serializer;

    localparam int D   = 4;
    localparam int DEP = 4;
`ifdef ESP_TX_PARITY_EN
    localparam int FW = 18;
    localparam logic [17:0] F_A5C3 = 18'h34B86;
    localparam logic [17:0] F_0001 = 18'h20003;
    localparam logic [17:0] F_0003 = 18'h20006;
`else
    localparam int FW = 17;
    localparam logic [17:0] F_A5C3 = 18'h1A5C3;
    localparam logic [17:0] F_0001 = 18'h10001;
    localparam logic [17:0] F_0003 = 18'h10003;
`endif
    localparam int N = FW * 2 * D + 4 * D;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        wr_valid = 1'b0;
    logic [15:0] wr_data = 16'h0;
    logic        wr_ready;
    logic [2:0]  fifo_count;
    logic        busy, done, SCLK, IO_SPI;

    esp_tx_serializer #(.CLK_DIV(D), .FIFO_DEPTH(DEP)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .fifo_count(fifo_count), .busy(busy), .done(done),
        .SCLK(SCLK), .IO_SPI(IO_SPI)
    );

    always #5 HCLK = ~HCLK;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: a queue of accepted words plus a countdown of busy cycles per frame.
    logic [15:0] mq[$];
    int          m_rem = 0;
    logic [15:0] m_cur = 16'h0;

    logic [17:0] cap = 18'h0;
    int          ncap = 0;
    logic [17:0] frames[$];
    int          nbits_q[$];
    logic        prev_sclk = 1'b0;
    logic        prev_io = 1'b0;

    function automatic logic [17:0] frame_of(input logic [15:0] w);
`ifdef ESP_TX_PARITY_EN
        return {1'b1, w, ^w};
`else
        return {1'b0, 1'b1, w};
`endif
    endfunction

    always @(posedge HCLK) begin : p_model
        int pre;
        bit acc;
        if (!HRESETn) begin
            mq.delete();
            m_rem = 0;
            cap = '0;
            ncap = 0;
        end else begin
            pre = mq.size();
            acc = wr_valid && (pre < DEP);
            if (m_rem > 0) m_rem--;
            else if (pre > 0) begin
                m_cur = mq.pop_front();
                m_rem = N;
            end
            if (acc) mq.push_back(wr_data);
        end
    end

    always @(negedge HCLK) begin : p_score
        int k;
        logic [17:0] f;
        logic e_sclk, e_io;
        if (chk_en) begin
            chk("count", 32'(fifo_count), 32'(mq.size()));
            chk("ready", 32'(wr_ready), 32'(mq.size() < DEP));
            chk("busy", 32'(busy), 32'(m_rem > 0));
            chk("done", 32'(done), 32'(m_rem == 4 * D));
            e_sclk = 1'b0;
            e_io   = 1'b0;
            if (m_rem > 4 * D) begin
                k = N - m_rem;
                f = frame_of(m_cur);
                e_sclk = (k % (2 * D)) >= D;
                e_io   = f[FW - 1 - k / (2 * D)];
            end
            chk("sclk", 32'(SCLK), 32'(e_sclk));
            chk("io", 32'(IO_SPI), 32'(e_io));
            if (SCLK === 1'b1 && prev_sclk === 1'b0) begin
                chk("io_stable", 32'(IO_SPI), 32'(prev_io));
                cap = {cap[16:0], IO_SPI};
                ncap++;
            end
            if (done === 1'b1) begin
                frames.push_back(cap);
                nbits_q.push_back(ncap);
                cap = '0;
                ncap = 0;
            end
        end
        prev_sclk = SCLK;
        prev_io   = IO_SPI;
    end

    task automatic step(input logic rn, input logic v, input logic [15:0] d);
        HRESETn  = rn;
        wr_valid = v;
        wr_data  = d;
        @(posedge HCLK);
        #2;
        cyc++;
    endtask

    task automatic idle_until_frames(input int want, input int budget);
        for (int c = 0; c < budget && frames.size() < want; c++) step(1'b1, 1'b0, 16'h0);
    endtask

    typedef struct {
        logic        rn;
        logic        v;
        logic [15:0] d;
        int          e_cnt;
        logic        e_rdy;
        logic        e_busy;
    } vec_t;
    vec_t tv[8];

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int t, tb0, td, nd;
        tv[0] = '{1'b0, 1'b1, 16'h1111, 0, 1'b1, 1'b0};
        tv[1] = '{1'b1, 1'b1, 16'h1001, 1, 1'b1, 1'b0};
        tv[2] = '{1'b1, 1'b1, 16'h1002, 1, 1'b1, 1'b1};
        tv[3] = '{1'b1, 1'b1, 16'h1003, 2, 1'b1, 1'b1};
        tv[4] = '{1'b1, 1'b1, 16'h1004, 3, 1'b1, 1'b1};
        tv[5] = '{1'b1, 1'b1, 16'h1005, 4, 1'b0, 1'b1};
        tv[6] = '{1'b1, 1'b1, 16'h1006, 4, 1'b0, 1'b1};
        tv[7] = '{1'b1, 1'b0, 16'h0000, 4, 1'b0, 1'b1};

        step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 16'h0);
        chk_en = 1;
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sclk", 32'(SCLK), 32'd0);

        // Six-cycle wr_valid burst from empty/idle.
        frames.delete(); nbits_q.delete();
        for (int i = 0; i < 8; i++) begin
            step(tv[i].rn, tv[i].v, tv[i].d);
            chk($sformatf("tv%0d_cnt", i), 32'(fifo_count), 32'(tv[i].e_cnt));
            chk($sformatf("tv%0d_rdy", i), 32'(wr_ready), 32'(tv[i].e_rdy));
            chk($sformatf("tv%0d_busy", i), 32'(busy), 32'(tv[i].e_busy));
        end
        idle_until_frames(5, 5 * N + 40);
        chk("burst_nframes", 32'(frames.size()), 32'd5);
        for (int i = 0; i < 5 && i < frames.size(); i++) begin
            chk($sformatf("burst_frame%0d", i), 32'(frames[i]), 32'(frame_of(16'h1001 + 16'(i))));
            chk($sformatf("burst_nbits%0d", i), 32'(nbits_q[i]), 32'(FW));
        end

        // Single word timing: done latency from SHIFT entry and gap length.
        step(1'b0, 1'b0, 16'h0);
        frames.delete(); nbits_q.delete();
        step(1'b1, 1'b1, 16'hA5C3);
        t = 0;
        while (busy !== 1'b1 && t < 10) begin step(1'b1, 1'b0, 16'h0); t++; end
        tb0 = cyc;
        t = 0;
        while (done !== 1'b1 && t < 400) begin step(1'b1, 1'b0, 16'h0); t++; end
        td = cyc;
        chk("a5c3_done_lat", 32'(td - tb0), 32'(FW * 2 * D));
        t = 0;
        while (busy !== 1'b0 && t < 100) begin step(1'b1, 1'b0, 16'h0); t++; end
        chk("a5c3_gap_lat", 32'(cyc - td), 32'(4 * D));
        chk("a5c3_nframes", 32'(frames.size()), 32'd1);
        if (frames.size() > 0) begin
            chk("a5c3_frame", 32'(frames[0]), 32'(F_A5C3));
            chk("a5c3_nbits", 32'(nbits_q[0]), 32'(FW));
        end

        // Push at full while the head is being popped.
        step(1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 16'h2000 + 16'(i));
        chk("full_cnt", 32'(fifo_count), 32'd4);
        t = 0;
        while (busy !== 1'b0 && t < N + 10) begin step(1'b1, 1'b0, 16'h0); t++; end
        chk("full_ready_lo", 32'(wr_ready), 32'd0);
        step(1'b1, 1'b1, 16'hDEAD);
        chk("full_pop_cnt", 32'(fifo_count), 32'd3);
        chk("full_pop_rdy", 32'(wr_ready), 32'd1);
        frames.delete(); nbits_q.delete();
        idle_until_frames(4, 4 * N + 40);
        chk("full_nframes", 32'(frames.size()), 32'd4);
        for (int i = 0; i < 4 && i < frames.size(); i++)
            chk($sformatf("full_frame%0d", i), 32'(frames[i]), 32'(frame_of(16'h2001 + 16'(i))));

        // Reset in the middle of bit 8 with three words queued.
        step(1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 16'h3000 + 16'(i));
        chk("mid_cnt", 32'(fifo_count), 32'd3);
        t = 0;
        while (ncap < 9 && t < 200) begin step(1'b1, 1'b0, 16'h0); t++; end
        chk("mid_reached_bit8", 32'(ncap), 32'd9);
        nd = frames.size();
        step(1'b0, 1'b1, 16'h5555);
        chk("mid_sclk", 32'(SCLK), 32'd0);
        chk("mid_io", 32'(IO_SPI), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_cnt0", 32'(fifo_count), 32'd0);
        chk("mid_done", 32'(done), 32'd0);
        for (int i = 0; i < 2 * N; i++) step(1'b1, 1'b0, 16'h0);
        chk("mid_no_done", 32'(frames.size()), 32'(nd));

        // Parity-relevant words.
        step(1'b0, 1'b0, 16'h0);
        frames.delete(); nbits_q.delete();
        step(1'b1, 1'b1, 16'h0001);
        step(1'b1, 1'b1, 16'h0003);
        idle_until_frames(2, 3 * N);
        chk("par_nframes", 32'(frames.size()), 32'd2);
        if (frames.size() >= 2) begin
            chk("par_frame0", 32'(frames[0]), 32'(F_0001));
            chk("par_frame1", 32'(frames[1]), 32'(F_0003));
            chk("par_nbits0", 32'(nbits_q[0]), 32'(FW));
            chk("par_nbits1", 32'(nbits_q[1]), 32'(FW));
`ifdef ESP_TX_PARITY_EN
            chk("par_bit0", 32'(frames[0][0]), 32'd1);
            chk("par_bit1", 32'(frames[1][0]), 32'd0);
`endif
        end

        // Random traffic with occasional resets.
        step(1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 3000; i++)
            step(logic'($urandom_range(0, 799) != 0), logic'($urandom_range(0, 2) == 0),
                 16'($urandom));
        for (int i = 0; i < 5 * N; i++) step(1'b1, 1'b0, 16'h0);
        chk("drain_empty", 32'(fifo_count), 32'd0);
        chk("drain_idle", 32'(busy), 32'd0);

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
